// File: rtl/ssd_count_pkg.sv
// ssd_count_pkg: shared constants, types and helpers for the display counter.
// Build option: SSD_COUNT_BCD_EN makes the default terminal value all-nines BCD.
package ssd_count_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Result of stepping one BCD digit: new digit plus carry/borrow out.
    typedef struct packed {
        logic                   carry;
        logic [BCD_DIGIT_W-1:0] digit;
    } bcd_step_t;

    // Increment (up=1) or decrement (up=0) one BCD digit when cin is set.
    function automatic bcd_step_t bcd_digit_step(
        input logic [BCD_DIGIT_W-1:0] digit,
        input logic                   up,
        input logic                   cin
    );
        bcd_step_t r;
        r.carry = 1'b0;
        r.digit = digit;
        if (cin) begin
            if (up) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    r.carry = 1'b1;
                    r.digit = '0;
                end else begin
                    r.digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    r.carry = 1'b1;
                    r.digit = BCD_MAX_DIGIT;
                end else begin
                    r.digit = digit - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Default terminal value: all ones in binary, all nines in BCD.
    function automatic longint unsigned default_max_count(input int width);
        longint unsigned v;
        v = 64'd0;
`ifdef SSD_COUNT_BCD_EN
        for (int i = 0; i < width / BCD_DIGIT_W; i++) begin
            v = (v << BCD_DIGIT_W) | 64'd9;
        end
`else
        v = (64'd1 << width) - 64'd1;
`endif
        return v;
    endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// ssd_prescaler: divides enabled cycles by PRESCALE and flags the last one.
// Independent of SSD_COUNT_BCD_EN.
module ssd_prescaler
    import ssd_count_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock_in,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    // One bit minimum so PRESCALE=1 still has a (constant-zero) phase register.
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase_reg;
    logic [CW-1:0] phase_next;

    // Advance the phase on enabled cycles; a clear restarts the period.
    always_comb begin
        phase_next = phase_reg;
        if (clear) begin
            phase_next = '0;
        end else if (enable) begin
            phase_next = (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
        end
    end

    // Phase register; reset discards any partial period.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

    assign tick = enable && (phase_reg == LAST);

endmodule

// File: rtl/ssd_count_gen.sv
// ssd_count_gen: prescaled up/down counter with load, terminal value and
// wrap/saturate behaviour. Define SSD_COUNT_BCD_EN for packed-BCD counting.
module ssd_count_gen
    import ssd_count_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter int              PRESCALE  = 1,
    parameter longint unsigned MAX_COUNT = default_max_count(WIDTH),
    parameter int              SATURATE  = 0
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam bit               SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] load_fix;
    logic [WIDTH-1:0] load_clamped;

    // A load restarts the step period so the next tick is a full period away.
    ssd_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock_in (clock_in),
        .reset    (reset),
        .enable   (enable),
        .clear    (load),
        .tick     (tick)
    );

`ifdef SSD_COUNT_BCD_EN
    localparam int DIGITS = WIDTH / BCD_DIGIT_W;

    // Ripple decimal carry (up) and borrow (down) across all digits.
    always_comb begin : bcd_arith
        bcd_step_t inc_s;
        bcd_step_t dec_s;
        logic      inc_c;
        logic      dec_c;
        inc_val = '0;
        dec_val = '0;
        inc_c   = 1'b1;
        dec_c   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            inc_s = bcd_digit_step(count_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W], 1'b1, inc_c);
            dec_s = bcd_digit_step(count_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W], 1'b0, dec_c);
            inc_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] = inc_s.digit;
            dec_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] = dec_s.digit;
            inc_c = inc_s.carry;
            dec_c = dec_s.carry;
        end
    end

    // Non-decimal load digits are pulled down to 9 before the terminal clamp.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_load_digit
        assign load_fix[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
            (load_value[gi*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) ?
            BCD_MAX_DIGIT : load_value[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
    end
    if (DIGITS * BCD_DIGIT_W < WIDTH) begin : g_load_pad
        assign load_fix[WIDTH-1:DIGITS*BCD_DIGIT_W] = '0;
    end
`else
    assign inc_val  = count_reg + 1'b1;
    assign dec_val  = count_reg - 1'b1;
    assign load_fix = load_value;
`endif

    // Packed BCD orders the same as binary, so one magnitude compare serves both.
    assign load_clamped = (load_fix > MAX_VAL) ? MAX_VAL : load_fix;

    // Next count/wrap: load beats step; limits either wrap or hold, and pulse wrap.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (tick) begin
            if (up_down) begin
                if (count_reg == MAX_VAL) begin
                    wrap_next = 1'b1;
                    if (!SAT) begin
                        count_next = '0;
                    end
                end else begin
                    count_next = inc_val;
                end
            end else begin
                if (count_reg == '0) begin
                    wrap_next = 1'b1;
                    if (!SAT) begin
                        count_next = MAX_VAL;
                    end
                end else begin
                    count_next = dec_val;
                end
            end
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_ssd_count_gen.sv
// tb_ssd_count_gen: five counter configurations driven from shared inputs,
// checked every cycle against a natural-number model plus literal expectations.
// Honours SSD_COUNT_BCD_EN when the design is built with it.
module tb_ssd_count_gen;

    localparam int N = 5;

`ifdef SSD_COUNT_BCD_EN
    localparam longint unsigned MAX_SMALL = 64'h09;
    localparam longint unsigned MAX_MID   = 64'h99;
    localparam int FULL_N = 99;
    localparam int E64    = 'h64;
    localparam int E65    = 'h65;
    localparam int E200   = 'h98;
    localparam int E201   = 'h99;
    localparam int EU4    = 'h98;
    localparam int EDOWN  = 'h99;
`else
    localparam longint unsigned MAX_SMALL = 64'd9;
    localparam longint unsigned MAX_MID   = 64'd99;
    localparam int FULL_N = 255;
    localparam int E64    = 64;
    localparam int E65    = 65;
    localparam int E200   = 200;
    localparam int E201   = 201;
    localparam int EU4    = 99;
    localparam int EDOWN  = 255;
`endif

    logic       clock_in = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] cnt_o  [N];
    logic       tick_o [N];
    logic       wrap_o [N];

    int errors = 0;
    int checks = 0;

    // Model state: count as a plain natural number, enabled cycles into period.
    int val [N];
    int ph  [N];
    bit wr  [N];
    bit valid = 1'b0;

    always #5 clock_in = ~clock_in;

    ssd_count_gen u0 (
        .clock_in(clock_in), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[0]), .tick(tick_o[0]), .wrap(wrap_o[0]));

    ssd_count_gen #(.PRESCALE(4)) u1 (
        .clock_in(clock_in), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[1]), .tick(tick_o[1]), .wrap(wrap_o[1]));

    ssd_count_gen #(.MAX_COUNT(MAX_SMALL)) u2 (
        .clock_in(clock_in), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[2]), .tick(tick_o[2]), .wrap(wrap_o[2]));

    ssd_count_gen #(.MAX_COUNT(MAX_SMALL), .SATURATE(1)) u3 (
        .clock_in(clock_in), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[3]), .tick(tick_o[3]), .wrap(wrap_o[3]));

    ssd_count_gen #(.PRESCALE(3), .MAX_COUNT(MAX_MID)) u4 (
        .clock_in(clock_in), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[4]), .tick(tick_o[4]), .wrap(wrap_o[4]));

    function automatic int pre_of(int k);
        return (k == 1) ? 4 : (k == 4) ? 3 : 1;
    endfunction

    function automatic bit sat_of(int k);
        return (k == 3);
    endfunction

    function automatic int max_of(int k);
        return (k == 2 || k == 3) ? 9 : (k == 4) ? 99 : FULL_N;
    endfunction

    // Natural value -> expected count encoding.
    function automatic int enc(int n);
`ifdef SSD_COUNT_BCD_EN
        return (n / 10) * 16 + (n % 10);
`else
        return n;
`endif
    endfunction

    // Load bus -> natural value before the terminal clamp.
    function automatic int load_nat(logic [7:0] v);
`ifdef SSD_COUNT_BCD_EN
        int hi;
        int lo;
        hi = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
        lo = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return hi * 10 + lo;
`else
        return int'(v);
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic lit(string name, int act, int exp);
        $display("txn %-16s got 0x%0h want 0x%0h", name, act, exp);
        check(name, act, exp);
    endtask

    // Apply one clock edge of the specified behaviour to every model instance.
    task automatic model_update();
        bit t;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                val[k] = 0;
                ph[k]  = 0;
                wr[k]  = 1'b0;
            end else if (load) begin
                val[k] = (load_nat(load_value) > max_of(k)) ? max_of(k) : load_nat(load_value);
                ph[k]  = 0;
                wr[k]  = 1'b0;
            end else begin
                t     = enable && (ph[k] == pre_of(k) - 1);
                wr[k] = 1'b0;
                if (enable) ph[k] = (ph[k] + 1) % pre_of(k);
                if (t) begin
                    if (up_down) begin
                        if (val[k] == max_of(k)) begin
                            wr[k] = 1'b1;
                            if (!sat_of(k)) val[k] = 0;
                        end else begin
                            val[k] = val[k] + 1;
                        end
                    end else begin
                        if (val[k] == 0) begin
                            wr[k] = 1'b1;
                            if (!sat_of(k)) val[k] = max_of(k);
                        end else begin
                            val[k] = val[k] - 1;
                        end
                    end
                end
            end
        end
        if (reset) valid = 1'b1;
    endtask

    // One cycle: check tick before the edge, advance model, check registers after.
    task automatic step();
        #2;
        if (valid) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("u%0d tick", k), int'(tick_o[k]),
                      int'(enable && (ph[k] == pre_of(k) - 1)));
            end
        end
        @(posedge clock_in);
        model_update();
        #1;
        if (valid) begin
            for (int k = 0; k < N; k++) begin
                check($sformatf("u%0d count", k), int'(cnt_o[k]), enc(val[k]));
                check($sformatf("u%0d wrap", k), int'(wrap_o[k]), int'(wr[k]));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 8'd0;
        @(posedge clock_in);
        #1;
        repeat (2) step();
        lit("reset count", int'(cnt_o[0]), 0);
        lit("reset wrap", int'(wrap_o[0]), 0);

        // Free-running up count from reset.
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 1)  lit("u0 first step", int'(cnt_o[0]), 1);
            if (i == 3)  lit("u1 pre tick", int'(cnt_o[1]), 0);
            if (i == 4)  lit("u1 first tick", int'(cnt_o[1]), 1);
            if (i == 10) lit("u2 wrap up", int'(cnt_o[2]), 0);
            if (i == 10) lit("u2 wrap pulse", int'(wrap_o[2]), 1);
            if (i == 20) lit("u3 sat hold", int'(cnt_o[3]), 9);
            if (i == 20) lit("u3 sat pulse", int'(wrap_o[3]), 1);
`ifdef SSD_COUNT_BCD_EN
            if (i == 99)  lit("u0 at max", int'(cnt_o[0]), 'h99);
            if (i == 100) lit("u0 roll", int'(cnt_o[0]), 0);
            if (i == 100) lit("u0 roll wrap", int'(wrap_o[0]), 1);
`else
            if (i == 255) lit("u0 at max", int'(cnt_o[0]), 255);
            if (i == 255) lit("u0 max nowrap", int'(wrap_o[0]), 0);
            if (i == 256) lit("u0 roll", int'(cnt_o[0]), 0);
            if (i == 256) lit("u0 roll wrap", int'(wrap_o[0]), 1);
`endif
        end

        // Pause enable mid-period: the next u1 tick slips by two cycles.
        step();
        lit("u1 mid period", int'(cnt_o[1]), E64);
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
        step();
        lit("u1 delayed", int'(cnt_o[1]), E64);
        step();
        lit("u1 resumed", int'(cnt_o[1]), E65);

        // Load zero, then count down through the lower limit.
        load       = 1'b1;
        load_value = 8'd0;
        up_down    = 1'b0;
        step();
        load = 1'b0;
        lit("u2 loaded", int'(cnt_o[2]), 0);
        step();
        lit("u2 down wrap", int'(cnt_o[2]), 9);
        lit("u2 down pulse", int'(wrap_o[2]), 1);
        lit("u3 down sat", int'(cnt_o[3]), 0);
        lit("u3 down pulse", int'(wrap_o[3]), 1);
        lit("u0 down wrap", int'(cnt_o[0]), EDOWN);
        step();
        lit("u2 down", int'(cnt_o[2]), 8);
        lit("u2 no pulse", int'(wrap_o[2]), 0);

        // Load above the terminal value while ticking: clamp, no step.
        up_down    = 1'b1;
        load       = 1'b1;
        load_value = 8'd200;
        step();
        load = 1'b0;
        lit("u4 clamp", int'(cnt_o[4]), EU4);
        lit("u0 load no step", int'(cnt_o[0]), E200);
        step();
        step();
        step();
        lit("u1 restart wait", int'(cnt_o[1]), E200);
        step();
        lit("u1 restart tick", int'(cnt_o[1]), E201);

        // Reset in the middle of a PRESCALE=3 period.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        lit("u4 reset", int'(cnt_o[4]), 0);
        step();
        step();
        lit("u4 post reset", int'(cnt_o[4]), 0);
        step();
        lit("u4 first tick", int'(cnt_o[4]), 1);

`ifdef SSD_COUNT_BCD_EN
        load = 1'b1; load_value = 8'h09; step();
        load = 1'b0; step();
        lit("bcd 09 up", int'(cnt_o[0]), 'h10);
        load = 1'b1; load_value = 8'h99; step();
        load = 1'b0; step();
        lit("bcd 99 up", int'(cnt_o[0]), 'h00);
        lit("bcd 99 wrap", int'(wrap_o[0]), 1);
        load = 1'b1; load_value = 8'h3F; step();
        load = 1'b0;
        lit("bcd load 3F", int'(cnt_o[0]), 'h39);
`else
        load = 1'b1; load_value = 8'hFF; step();
        load = 1'b0; step();
        lit("bin FF up", int'(cnt_o[0]), 0);
        lit("bin FF wrap", int'(wrap_o[0]), 1);
        load = 1'b1; load_value = 8'h3F; step();
        load = 1'b0;
        lit("bin load 3F", int'(cnt_o[0]), 'h3F);
`endif
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
